// File: rtl/mmio_led_pwm.sv
// Memory-mapped LED/PWM peripheral with glitch-free duty reload and a millisecond counter.
// Word-addressed register bank inside a 256-byte region; all outputs active-high.
module mmio_led_pwm #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int unsigned CLK_PER_MS = 12000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [3:0]  wmask,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam logic [5:0]  A_CTRL     = 6'h00;
  localparam logic [5:0]  A_DUTY_R   = 6'h01;
  localparam logic [5:0]  A_DUTY_G   = 6'h02;
  localparam logic [5:0]  A_DUTY_B   = 6'h03;
  localparam logic [5:0]  A_PRESCALE = 6'h04;
  localparam logic [5:0]  A_MILLIS   = 6'h05;
  localparam logic [5:0]  A_STATUS   = 6'h06;
  localparam logic [31:0] MS_LAST    = 32'(CLK_PER_MS - 1);

  logic [1:0]  ctrl;
  logic [7:0]  shadow_r, shadow_g, shadow_b;
  logic [7:0]  active_r, active_g, active_b;
  logic [15:0] prescale;
  logic        wrap;
  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [31:0] ms_cnt;
  logic [31:0] millis;
  logic [5:0]  idx;
  logic        wr;
  logic        pwm_en;
  logic        tick;
  logic        period_end;
  logic        wrap_clr;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign hit         = (addr[31:8] == BASE_ADDR[31:8]);
  assign idx         = addr[7:2];
  assign wr          = we & hit;
  assign pwm_en      = ctrl[1];
  assign tick        = pwm_en & (pre_cnt >= prescale);
  assign period_end  = tick & (pwm_cnt == 8'hFF);
  assign wrap_clr    = wr & (idx == A_STATUS) & wmask[0] & wdata[0];
  assign unused_bits = ^{addr[1:0], wdata[31:16], wmask[3:2]};

  always_comb begin
    rd_mux = '0;
    case (idx)
      A_CTRL:     rd_mux = {30'd0, ctrl};
      A_DUTY_R:   rd_mux = {24'd0, shadow_r};
      A_DUTY_G:   rd_mux = {24'd0, shadow_g};
      A_DUTY_B:   rd_mux = {24'd0, shadow_b};
      A_PRESCALE: rd_mux = {16'd0, prescale};
      A_MILLIS:   rd_mux = millis;
      A_STATUS:   rd_mux = {31'd0, wrap};
      default:    rd_mux = '0;
    endcase
  end

  // Byte lanes that carry no implemented bits are simply dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      shadow_r <= '0;
      shadow_g <= '0;
      shadow_b <= '0;
      prescale <= '0;
    end else if (wr) begin
      case (idx)
        A_CTRL:   if (wmask[0]) ctrl <= wdata[1:0];
        A_DUTY_R: if (wmask[0]) shadow_r <= wdata[7:0];
        A_DUTY_G: if (wmask[0]) shadow_g <= wdata[7:0];
        A_DUTY_B: if (wmask[0]) shadow_b <= wdata[7:0];
        A_PRESCALE: begin
          if (wmask[0]) prescale[7:0]  <= wdata[7:0];
          if (wmask[1]) prescale[15:8] <= wdata[15:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          wrap <= 1'b0;
    else if (period_end) wrap <= 1'b1;
    else if (wrap_clr)   wrap <= 1'b0;
  end

  // Active duties only change at a period boundary, or freely while the PWM is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      active_r <= '0;
      active_g <= '0;
      active_b <= '0;
    end else if (!pwm_en) begin
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      active_r <= shadow_r;
      active_g <= shadow_g;
      active_b <= shadow_b;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
      if (period_end) begin
        active_r <= shadow_r;
        active_g <= shadow_g;
        active_b <= shadow_b;
      end
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_cnt <= '0;
      millis <= '0;
    end else if (ms_cnt == MS_LAST) begin
      ms_cnt <= '0;
      millis <= millis + 32'd1;
    end else begin
      ms_cnt <= ms_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      led   <= 1'b0;
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      rdata <= hit ? rd_mux : 32'd0;
      led   <= ctrl[0];
      red   <= pwm_en & (pwm_cnt < active_r);
      green <= pwm_en & (pwm_cnt < active_g);
      blue  <= pwm_en & (pwm_cnt < active_b);
    end
  end

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Self-checking bench for mmio_led_pwm: a register/PWM reference model compared every cycle,
// plus directed checks with hand-computed values and a randomized bus phase.
module tb_mmio_led_pwm;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int          CPM  = 12000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [3:0]  wmask = '0;
  logic        hit;
  logic [31:0] rdata;
  logic        led, red, green, blue;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  bit last_red = 1'b0;

  // Reference model state
  logic [1:0]  m_ctrl;
  logic [7:0]  m_shadow [3];
  logic [7:0]  m_active [3];
  logic [15:0] m_pre_lim;
  bit          m_wrap;
  int unsigned m_pre;
  int unsigned m_pwm;
  longint      m_cycles;
  logic [31:0] e_rdata;
  bit          e_led;
  bit          e_rgb [3];

  int          op;
  logic [7:0]  off;
  logic [31:0] rd;
  int          hi, len, cnt_r, cnt_g, cnt_b_low;

  mmio_led_pwm dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .wmask(wmask),
    .hit(hit), .rdata(rdata), .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] reg_value(input int idx);
    case (idx)
      0:       return {30'd0, m_ctrl};
      1, 2, 3: return {24'd0, m_shadow[idx-1]};
      4:       return {16'd0, m_pre_lim};
      5:       return 32'(m_cycles / CPM);
      6:       return {31'd0, m_wrap};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_pre_lim = '0; m_wrap = 0; m_pre = 0; m_pwm = 0; m_cycles = 0;
    e_rdata = '0; e_led = 0;
    for (int i = 0; i < 3; i++) begin
      m_shadow[i] = '0; m_active[i] = '0; e_rgb[i] = 0;
    end
  endtask

  task automatic model_step();
    bit h, commit, en, tk;
    int idx;
    logic [31:0] nv;
    logic [7:0] old_shadow [3];
    h      = (addr[31:8] == BASE[31:8]);
    idx    = int'(addr[7:2]);
    commit = we && h;
    en     = m_ctrl[1];
    e_rdata = h ? reg_value(idx) : 32'd0;
    e_led   = m_ctrl[0];
    for (int i = 0; i < 3; i++) begin
      e_rgb[i] = en && (m_pwm < 32'(m_active[i]));
      old_shadow[i] = m_shadow[i];
    end
    tk = en && (m_pre >= 32'(m_pre_lim));
    if (tk && m_pwm == 255) m_wrap = 1;
    else if (commit && idx == 6 && wmask[0] && wdata[0]) m_wrap = 0;
    if (!en) begin
      m_pre = 0; m_pwm = 0; m_active = old_shadow;
    end else if (tk) begin
      if (m_pwm == 255) m_active = old_shadow;
      m_pwm = (m_pwm + 1) % 256;
      m_pre = 0;
    end else begin
      m_pre++;
    end
    m_cycles++;
    if (commit) begin
      case (idx)
        0: begin nv = merge({30'd0, m_ctrl}, wdata, wmask); m_ctrl = nv[1:0]; end
        1, 2, 3: begin
          nv = merge({24'd0, m_shadow[idx-1]}, wdata, wmask); m_shadow[idx-1] = nv[7:0];
        end
        4: begin nv = merge({16'd0, m_pre_lim}, wdata, wmask); m_pre_lim = nv[15:0]; end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("hit", 32'(hit), 32'(addr[31:8] == BASE[31:8]));
      check("rdata", rdata, e_rdata);
      check("led", 32'(led), 32'(e_led));
      check("red", 32'(red), 32'(e_rgb[0]));
      check("green", 32'(green), 32'(e_rgb[1]));
      check("blue", 32'(blue), 32'(e_rgb[2]));
    end
  end

  task automatic step();
    last_red = red;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [3:0] m);
    addr = a; wdata = d; we = w; wmask = m;
    step();
    addr = '0; wdata = '0; we = 1'b0; wmask = '0;
  endtask

  task automatic write_reg(input logic [7:0] o, input logic [31:0] d, input logic [3:0] m);
    drive(BASE | {24'd0, o}, d, 1'b1, m);
  endtask

  task automatic read_reg(input logic [7:0] o, output logic [31:0] v);
    drive(BASE | {24'd0, o}, 32'd0, 1'b0, 4'h0);
    v = rdata;
  endtask

  task automatic wait_rise();
    bit done;
    done = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      step();
      if (red && !last_red) done = 1;
    end
    if (!done) check("rise_timeout", 32'd1, 32'd0);
  endtask

  // Starts on a red rising edge; counts high samples and length up to the next rise.
  task automatic measure_period(input int write_at, input logic [7:0] o, input logic [31:0] d,
                                output int h, output int l);
    bit done;
    done = 0; h = 1; l = 1;
    for (int k = 0; k < 5000 && !done; k++) begin
      if (l == write_at) begin
        addr = BASE | {24'd0, o}; wdata = d; we = 1'b1; wmask = 4'hF;
      end else begin
        addr = '0; wdata = '0; we = 1'b0; wmask = '0;
      end
      step();
      if (red && !last_red) done = 1;
      else begin h += int'(red); l++; end
    end
    addr = '0; we = 1'b0; wdata = '0; wmask = '0;
    if (!done) check("period_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    check_en = 1'b1;
    check("rst_led", 32'(led), 32'd0);
    check("rst_red", 32'(red), 32'd0);
    check("rst_green", 32'(green), 32'd0);
    check("rst_blue", 32'(blue), 32'd0);
    for (int i = 0; i < 8; i++) begin
      read_reg(8'(i * 4), rd);
      check("rst_read", rd, 32'd0);
    end

    write_reg(8'h00, 32'h1, 4'hF);
    check("led_not_yet", 32'(led), 32'd0);
    step();
    check("led_one_later", 32'(led), 32'd1);
    write_reg(8'h00, 32'h2, 4'b0010);
    read_reg(8'h00, rd);
    check("ctrl_masked", rd, 32'h1);
    addr = 32'h0; wdata = 32'h0; we = 1'b1; wmask = 4'hF;
    #1 check("miss_hit", 32'(hit), 32'd0);
    step();
    we = 1'b0;
    check("miss_rdata", rdata, 32'd0);
    read_reg(8'h00, rd);
    check("ctrl_after_miss", rd, 32'h1);

    while (m_cycles < CPM) step();
    read_reg(8'h14, rd);
    check("millis_one", rd, 32'd1);

    write_reg(8'h10, 32'd0, 4'hF);
    write_reg(8'h04, 32'd64, 4'hF);
    write_reg(8'h08, 32'd0, 4'hF);
    write_reg(8'h0C, 32'd255, 4'hF);
    write_reg(8'h00, 32'h2, 4'hF);
    repeat (300) step();
    cnt_r = 0; cnt_g = 0; cnt_b_low = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      cnt_r += int'(red); cnt_g += int'(green); cnt_b_low += int'(!blue);
    end
    check("red_64", 32'(cnt_r), 32'd64);
    check("green_0", 32'(cnt_g), 32'd0);
    check("blue_low_1", 32'(cnt_b_low), 32'd1);

    wait_rise();
    measure_period(100, 8'h04, 32'd128, hi, len);
    check("old_duty_hi", 32'(hi), 32'd64);
    check("old_duty_len", 32'(len), 32'd256);
    measure_period(-1, 8'h00, 32'd0, hi, len);
    check("new_duty_hi", 32'(hi), 32'd128);
    check("new_duty_len", 32'(len), 32'd256);

    read_reg(8'h18, rd);
    check("status_set", rd, 32'd1);
    write_reg(8'h18, 32'd0, 4'hF);
    read_reg(8'h18, rd);
    check("status_w0", rd, 32'd1);
    wait_rise();
    write_reg(8'h18, 32'd1, 4'hF);
    read_reg(8'h18, rd);
    check("status_w1c", rd, 32'd0);
    repeat (252) step();
    write_reg(8'h18, 32'd1, 4'hF);
    read_reg(8'h18, rd);
    check("status_set_wins", rd, 32'd1);

    write_reg(8'h10, 32'd3, 4'hF);
    wait_rise();
    measure_period(-1, 8'h00, 32'd0, hi, len);
    measure_period(-1, 8'h00, 32'd0, hi, len);
    check("pre3_len", 32'(len), 32'd1024);
    check("pre3_hi", 32'(hi), 32'd512);

    write_reg(8'h00, 32'h3, 4'hF);
    wait_rise();
    #2 reset = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'd0);
    check("arst_red", 32'(red), 32'd0);
    check("arst_blue", 32'(blue), 32'd0);
    check("arst_rdata", rdata, 32'd0);
    step();
    step();
    reset = 1'b1;
    cnt_r = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      cnt_r += int'(red) + int'(green) + int'(blue);
    end
    check("idle_after_rst", 32'(cnt_r), 32'd0);
    read_reg(8'h00, rd);
    check("ctrl_after_rst", rd, 32'd0);

    write_reg(8'h00, 32'h2, 4'hF);
    for (int i = 0; i < 4000; i++) begin
      op  = int'($urandom_range(0, 9));
      off = 8'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      rd  = $urandom;
      if (off[7:2] == 6'd4) rd = 32'($urandom_range(0, 3));
      if (op <= 3)      drive(BASE | {24'd0, off}, rd, 1'b1, 4'($urandom_range(0, 15)));
      else if (op <= 5) drive(BASE | {24'd0, off}, 32'd0, 1'b0, 4'h0);
      else if (op == 6) drive($urandom & 32'h7FFF_FFFF, rd, 1'b1, 4'hF);
      else              step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_led_pwm.md
# mmio_led_pwm

Memory-mapped LED/PWM peripheral that responds to the multicycle RISC-V core's load/store data port. It decodes a 256-byte region, holds duty-cycle and control registers, and drives the board LED and the RGB channels with 8-bit PWM. It also provides a read-only millisecond counter. Outputs are active-high; the top level inverts them for the active-low board pins.

## Interface
- BASE_ADDR, 32'hFFFF_FF00: region base; only addr[31:8] is compared.
- CLK_PER_MS, 12000: clock cycles per millisecond tick (12 MHz board clock).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from the core's memory address mux.
- wdata  in  32  store data.
- we  in  1  store strobe (core MemWrite), one cycle per store.
- wmask  in  4  byte enables for wdata[8k+7:8k].
- hit  out  1  combinational: addr[31:8] == BASE_ADDR[31:8]; the memory uses it to steer read data and suppress RAM writes.
- rdata  out  32  registered read data.
- led  out  1  user LED, active-high.
- red, green, blue  out  1 each  PWM outputs, active-high, registered.

## Operation
- Register map (offset addr[7:0]; word-aligned; addr[1:0] ignored):
  - 0x00 CTRL, RW: bit0 = led; bit1 = pwm_en. Other bits read 0.
  - 0x04 DUTY_R, 0x08 DUTY_G, 0x0C DUTY_B, RW [7:0]: written value is held in a shadow register.
  - 0x10 PRESCALE, RW [15:0].
  - 0x14 MILLIS, RO [31:0]. Writes are ignored.
  - 0x18 STATUS, bit0 = wrap sticky flag. Writing 1 clears it; writing 0 has no effect.
  - Any other offset reads 0, and writes to it are ignored.
- A write commits when `we & hit`. Only bytes with wmask set are updated. Bytes that map to unimplemented bits are dropped.
- Prescaler: 16-bit `pre_cnt` counts from 0 to PRESCALE, then returns to 0 and emits a one-cycle `tick`. With PRESCALE=0, a tick occurs every cycle.
- PWM counter: 8-bit `pwm_cnt` increments on each tick and wraps from 255 to 0.
- Shadow duty registers load into the active duty registers on the tick where pwm_cnt goes 255→0. That tick also sets STATUS.wrap. This makes duty changes glitch-free.
- Channel output: `red <= pwm_en & (pwm_cnt < duty_r_active)`, and likewise for green and blue.
  - duty 0 gives always off.
  - duty 255 gives on for 255 of 256 counts.
- When pwm_en=0:
  - pre_cnt and pwm_cnt hold at 0.
  - Active duties load from the shadows every cycle.
  - red, green and blue are 0.
- `led <= CTRL.led` (registered, one cycle behind the write).
- MILLIS: a `ms_cnt` counts 0 to CLK_PER_MS-1. On wrap, MILLIS increments, wrapping from 2^32-1 to 0. It runs regardless of pwm_en.
- Simultaneous events:
  - Hardware set of STATUS.wrap and a W1C in the same cycle: set wins (flag stays 1).
  - A DUTY write in the same cycle as the 255→0 reload: the active register takes the old shadow value. The new value applies at the next wrap.
  - A PRESCALE write mid-count: the new limit is used from the next cycle. If pre_cnt is already greater than or equal to the new limit, it ticks and resets on the next cycle.

## Timing
- Reset (asynchronous assert, release on the next edge) clears everything to 0:
  - CTRL, shadow and active duties, PRESCALE, STATUS
  - pre_cnt, pwm_cnt, ms_cnt, MILLIS
  - rdata, led, red, green, blue
- Reset asserted mid-period forces all outputs low immediately, with no wait for a clock edge.
- Read latency is 1 cycle. At each edge, `rdata <= hit ? reg[addr[7:2]] : 0`. The value is valid in the cycle after addr is presented, which matches the core's MemRead→MemWB step.
- A read of a register written in the previous cycle returns the new value.
- Writes are visible in register state at the edge where we&hit is sampled.
- PWM period = 256 × (PRESCALE+1) cycles.
- Outputs change one cycle after the pwm_cnt edge that crosses the duty value.
- `hit` is purely combinational from addr and has no clock dependence.

## Test plan
- Reset release, then read all offsets 0x00–0x1C.
  - Required: every read returns 0; led, red, green and blue are 0.
  - MILLIS reads 1 after 12000 cycles.
- Write CTRL=0x1.
  - Required: led=1 one cycle later.
  - Write 0x00000002 with wmask=4'b0010: CTRL unchanged (byte 1 holds no bits).
  - Write with addr=0x0000_0000 (miss): no change; hit=0; rdata=0.
- PRESCALE=0, DUTY_R=64, CTRL=0x2.
  - Required: after the first wrap, red is high for exactly 64 of every 256 cycles.
  - DUTY_G=0: green stays 0. DUTY_B=255: blue is low exactly 1 cycle per period.
- Change DUTY_R from 64 to 128 mid-period.
  - Required: the current period keeps 64 high cycles; the next period has 128.
  - STATUS reads 1 after the wrap. Writing 1 clears it. A W1C issued on the wrap tick leaves it at 1.
- PRESCALE=3.
  - Required: the period measures 1024 cycles.
  - Assert reset mid-period: all outputs drop within the same cycle, before any clock edge. After release, PWM stays idle until pwm_en is set again.
